// File: rtl/multicycle_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cpu_pkg
//  Description : Opcode map, FSM state encoding and shared helpers for the
//                multi-cycle 16-bit-ISA core.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_cpu_pkg;

    typedef logic [2:0] state_t;
    typedef logic [3:0] opcode_t;

    localparam int      C_NUM_REGS = 16;
    localparam logic [3:0] C_LINK_REG = 4'd15;

    localparam logic [2:0] C_FETCH  = 3'd0;
    localparam logic [2:0] C_DECODE = 3'd1;
    localparam logic [2:0] C_EXEC   = 3'd2;
    localparam logic [2:0] C_MEM    = 3'd3;
    localparam logic [2:0] C_WB     = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    localparam logic [3:0] C_OP_ADD  = 4'h0;
    localparam logic [3:0] C_OP_SUB  = 4'h1;
    localparam logic [3:0] C_OP_AND  = 4'h2;
    localparam logic [3:0] C_OP_OR   = 4'h3;
    localparam logic [3:0] C_OP_SLT  = 4'h4;
    localparam logic [3:0] C_OP_ADDI = 4'h5;
    localparam logic [3:0] C_OP_LW   = 4'h6;
    localparam logic [3:0] C_OP_SW   = 4'h7;
    localparam logic [3:0] C_OP_BEQ  = 4'h8;
    localparam logic [3:0] C_OP_JAL  = 4'h9;
    localparam logic [3:0] C_OP_JR   = 4'hA;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    // Register-register ALU ops write rd; every other writer targets rt.
    function automatic logic is_alu_rr(input opcode_t op);
        return (op <= C_OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cpu_if
//  Description : Shared instruction/data memory port with req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_cpu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mc_regfile
//  Description : 16 x DATA_W register file, two async reads, one sync write,
//                R0 hardwired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_regfile
    import multicycle_cpu_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [3:0]        ra1,
    input  wire logic [3:0]        ra2,
    output logic      [DATA_W-1:0] rd1,
    output logic      [DATA_W-1:0] rd2,
    input  wire logic              we,
    input  wire logic [3:0]        wa,
    input  wire logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] r_regs [C_NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (wa != 4'd0)) begin
            r_regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 4'd0) ? '0 : r_regs[ra1];
    assign rd2 = (ra2 == 4'd0) ? '0 : r_regs[ra2];

endmodule
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cpu
//  Description : Multi-cycle 16-bit-ISA core, FETCH/DECODE/EXEC/MEM/WB/HALT,
//                single shared memory port. Define MULTICYCLE_CPU_PERF_CNT_EN
//                to build the cycle/retired performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  wire logic        CLK,
    input  wire logic        RESET,
    multicycle_cpu_if.master mem,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       instr_out,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;

    opcode_t           w_op;
    logic [3:0]        w_rs;
    logic [3:0]        w_rt;
    logic [3:0]        w_rd;
    logic [DATA_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rb;
    logic [DATA_W-1:0] w_imm;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jal_off;
    logic [DATA_W-1:0] w_alu;
    logic              w_slt;
    logic              w_rf_we;
    logic [3:0]        w_rf_wa;
    logic [DATA_W-1:0] w_rf_wd;

    assign w_op = r_ir[15:12];
    assign w_rs = r_ir[11:8];
    assign w_rt = r_ir[7:4];
    assign w_rd = r_ir[3:0];

    assign w_imm     = DATA_W'($signed(r_ir[3:0]));
    assign w_br_off  = ADDR_W'($signed({r_ir[3:0], 1'b0}));
    assign w_jal_off = ADDR_W'($signed({r_ir[7:0], 1'b0}));

    mc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk   (CLK),
        .rst_n (RESET),
        .ra1   (w_rs),
        .ra2   (w_rt),
        .rd1   (w_ra),
        .rd2   (w_rb),
        .we    (w_rf_we),
        .wa    (w_rf_wa),
        .wd    (w_rf_wd)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_FETCH:  if (mem.ack) w_next = C_DECODE;
            C_DECODE: w_next = C_EXEC;
            C_EXEC: begin
                case (w_op)
                    C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR,
                    C_OP_SLT, C_OP_ADDI:  w_next = C_WB;
                    C_OP_LW, C_OP_SW:     w_next = C_MEM;
                    C_OP_HALT:            w_next = C_HALT;
                    default:              w_next = C_FETCH;
                endcase
            end
            C_MEM:    if (mem.ack) w_next = (w_op == C_OP_LW) ? C_WB : C_FETCH;
            C_WB:     w_next = C_FETCH;
            C_HALT:   w_next = C_HALT;
            default:  w_next = C_FETCH;
        endcase
    end

    assign w_slt = ($signed(r_a) < $signed(r_b));

    always_comb begin
        w_alu = r_a + w_imm;
        case (w_op)
            C_OP_ADD: w_alu = r_a + r_b;
            C_OP_SUB: w_alu = r_a - r_b;
            C_OP_AND: w_alu = r_a & r_b;
            C_OP_OR:  w_alu = r_a | r_b;
            C_OP_SLT: w_alu = DATA_W'(w_slt);
            default:  w_alu = r_a + w_imm;
        endcase
    end

    // JAL links in EXEC so the register is visible to the very next DECODE.
    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wa = w_rt;
        w_rf_wd = r_alu;
        if (r_state == C_WB) begin
            w_rf_we = 1'b1;
            w_rf_wa = is_alu_rr(w_op) ? w_rd : w_rt;
            w_rf_wd = (w_op == C_OP_LW) ? r_mdr : r_alu;
        end else if ((r_state == C_EXEC) && (w_op == C_OP_JAL)) begin
            w_rf_we = 1'b1;
            w_rf_wa = C_LINK_REG;
            w_rf_wd = DATA_W'(r_pc);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= C_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                C_FETCH: begin
                    if (mem.ack) begin
                        r_ir <= mem.rdata[15:0];
                        r_pc <= r_pc + ADDR_W'(2);
                    end
                end
                C_DECODE: begin
                    r_a <= w_ra;
                    r_b <= w_rb;
                end
                C_EXEC: begin
                    r_alu <= w_alu;
                    case (w_op)
                        C_OP_BEQ: if (r_a == r_b) r_pc <= r_pc + w_br_off;
                        C_OP_JAL: r_pc <= r_pc + w_jal_off;
                        C_OP_JR:  r_pc <= ADDR_W'(r_a);
                        default:  ;
                    endcase
                end
                C_MEM: begin
                    if (mem.ack && (w_op == C_OP_LW)) r_mdr <= mem.rdata;
                end
                default: ;
            endcase
        end
    end

    // Gating with RESET drops the request the instant reset asserts.
    assign mem.req   = RESET && ((r_state == C_FETCH) || (r_state == C_MEM));
    assign mem.we    = (r_state == C_MEM) && (w_op == C_OP_SW);
    assign mem.addr  = (r_state == C_MEM) ? ADDR_W'(r_alu) : r_pc;
    assign mem.wdata = r_b;

    assign halted    = (r_state == C_HALT);
    assign pc_out    = r_pc;
    assign instr_out = r_ir;

`ifdef MULTICYCLE_CPU_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retired_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (r_state != C_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (((w_next == C_FETCH) && (r_state != C_FETCH)) ||
                ((w_next == C_HALT)  && (r_state != C_HALT))) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_cpu
//  Description : Directed self-checking bench for multicycle_cpu (16- and
//                32-bit data builds) with a wait-state memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cpu;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    multicycle_cpu_if #(.DATA_W(16), .ADDR_W(16)) mif   ();
    multicycle_cpu_if #(.DATA_W(32), .ADDR_W(16)) mif32 ();

    logic        halted, halted32;
    logic [15:0] pc_out, pc32, instr_out, instr32;
    logic [31:0] cycle_cnt, retired_cnt, cyc32, ret32;

    multicycle_cpu #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RESET(RESET), .mem(mif),
        .halted(halted), .pc_out(pc_out), .instr_out(instr_out),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    multicycle_cpu #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'h0000)) dut32 (
        .CLK(CLK), .RESET(RESET), .mem(mif32),
        .halted(halted32), .pc_out(pc32), .instr_out(instr32),
        .cycle_cnt(cyc32), .retired_cnt(ret32)
    );

    // 32-bit core: ADDI r1,r0,-1 ; HALT, zero-wait ROM
    assign mif32.ack   = mif32.req;
    assign mif32.rdata = (mif32.addr == 16'h0000) ? 32'h0000_501F :
                         (mif32.addr == 16'h0002) ? 32'h0000_F000 : 32'h0;

    // 16-bit memory with programmable wait states
    logic [15:0] mem [128];
    int          mwait = 0;
    int          wcnt  = 0;
    logic        load_en = 1'b0;
    logic [6:0]  load_idx = '0;
    logic [15:0] load_val = '0;
    int          cyc_no = 0;
    int          req_start [128];
    logic        prev_req = 1'b0;
    int          wr_cnt = 0;
    logic [15:0] last_waddr = '0, last_wdata = '0;
    int          last_wlen = 0;
    logic [15:0] rd_q [$];

    assign mif.ack   = mif.req && (wcnt == mwait);
    assign mif.rdata = mem[mif.addr[7:1]];

    always @(posedge CLK) begin
        cyc_no   <= cyc_no + 1;
        prev_req <= mif.req;
        if (load_en) mem[load_idx] <= load_val;
        if (mif.req && !prev_req) begin
            req_start[mif.addr[7:1]] <= cyc_no;
            if (!mif.we) rd_q.push_back(mif.addr);
        end
        if (mif.req && mif.ack) begin
            wcnt <= 0;
            if (mif.we) begin
                mem[mif.addr[7:1]] <= mif.wdata;
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= mif.addr;
                last_wdata <= mif.wdata;
                last_wlen  <= wcnt + 1;
            end
        end else if (mif.req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [15:0] baddr, input logic [15:0] v);
        load_idx = baddr[7:1];
        load_val = v;
        load_en  = 1'b1;
        @(negedge CLK);
        load_en  = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          wbase;
        int          quiet_req;
        int          n;
        logic [31:0] c0;
        logic [31:0] exp_cyc, exp_ret, exp_ret4;
        logic        seen;

`ifdef MULTICYCLE_CPU_PERF_CNT_EN
        exp_cyc = 32'd15; exp_ret = 32'd4; exp_ret4 = 32'd12;
`else
        exp_cyc = 32'd0;  exp_ret = 32'd0; exp_ret4 = 32'd0;
`endif

        // ---------------- phase 1: ALU ops, zero wait, HALT -------------
        #2 RESET = 1'b0;
        mwait = 0;
        repeat (2) @(negedge CLK);
        chk("rst_pc",     {16'b0, pc_out},    32'h0);
        chk("rst_ir",     {16'b0, instr_out}, 32'h0);
        chk("rst_req",    {31'b0, mif.req},   32'h0);
        chk("rst_halted", {31'b0, halted},    32'h0);
        chk("rst_cycles", cycle_cnt,          32'h0);
        ld(16'h00, 16'h5015);   // ADDI r1,r0,5
        ld(16'h02, 16'h502D);   // ADDI r2,r0,-3
        ld(16'h04, 16'h0123);   // ADD  r3,r1,r2
        ld(16'h06, 16'hF000);   // HALT
        RESET = 1'b1;
        wait_halt(200, "p1_halt");
        chk("p1_r1", {16'b0, dut.u_regfile.r_regs[1]}, 32'h0005);
        chk("p1_r2", {16'b0, dut.u_regfile.r_regs[2]}, 32'hFFFD);
        chk("p1_r3", {16'b0, dut.u_regfile.r_regs[3]}, 32'h0002);
        chk("p1_add_latency", req_start[3] - req_start[2], 32'd4);
        c0 = cycle_cnt;
        quiet_req = 0;
        repeat (20) begin
            @(negedge CLK);
            if (mif.req) quiet_req++;
        end
        chk("halt_req_quiet", quiet_req, 32'd0);
        chk("halt_still",   {31'b0, halted}, 32'd1);
        chk("cycle_frozen", cycle_cnt, c0);
        chk("cycle_value",  cycle_cnt, exp_cyc);
        chk("retired_value", retired_cnt, exp_ret);
        chk("d32_halt", {31'b0, halted32}, 32'd1);
        chk("d32_r1", dut32.u_regfile.r_regs[1], 32'hFFFF_FFFF);

        // ---------------- phase 2: SW/LW with 3 wait states -------------
        RESET = 1'b0;
        mwait = 3;
        @(negedge CLK);
        ld(16'h06, 16'h7032);   // SW r3,2(r0)
        ld(16'h08, 16'h6042);   // LW r4,2(r0)
        ld(16'h0A, 16'hF000);   // HALT
        ld(16'h02, 16'h502D);
        wbase = wr_cnt;
        RESET = 1'b1;
        wait_halt(400, "p2_halt");
        chk("p2_wr_count", wr_cnt - wbase, 32'd1);
        chk("p2_waddr", {16'b0, last_waddr}, 32'h0002);
        chk("p2_wdata", {16'b0, last_wdata}, 32'h0002);
        chk("p2_req_len", last_wlen, 32'd4);
        chk("p2_r4", {16'b0, dut.u_regfile.r_regs[4]}, 32'h0002);

        // ---------------- phase 3: taken BEQ backwards ------------------
        RESET = 1'b0;
        mwait = 0;
        @(negedge CLK);
        ld(16'h02, 16'h502D);
        ld(16'h04, 16'hB000);   // undefined op -> NOP
        ld(16'h06, 16'hB000);
        ld(16'h08, 16'hB000);
        ld(16'h0A, 16'hB000);
        ld(16'h0C, 16'h8001);   // BEQ r0,r0,+1 -> 0x10
        ld(16'h0E, 16'hF000);   // HALT
        ld(16'h10, 16'h811E);   // BEQ r1,r1,-2 -> 0x0E
        base = rd_q.size();
        RESET = 1'b1;
        wait_halt(200, "p3_halt");
        chk("p3_fetch_len", rd_q.size() - base, 32'd9);
        chk("p3_fetch_10", {16'b0, rd_q[base+7]}, 32'h0010);
        chk("p3_taken_0E", {16'b0, rd_q[base+8]}, 32'h000E);
        chk("p3_beq_latency", req_start[7] - req_start[8], 32'd3);

        // ---------------- phase 4: BEQ not taken, JAL, JR ---------------
        RESET = 1'b0;
        @(negedge CLK);
        ld(16'h10, 16'h8125);   // BEQ r1,r2,+5 (not taken)
        ld(16'h12, 16'h8006);   // BEQ r0,r0,+6 -> 0x20
        ld(16'h20, 16'h9004);   // JAL +4 -> 0x2A, r15=0x22
        ld(16'h22, 16'hF000);   // HALT
        ld(16'h2A, 16'hAF00);   // JR r15
        base = rd_q.size();
        RESET = 1'b1;
        wait_halt(300, "p4_halt");
        chk("p4_nt_12",   {16'b0, rd_q[base+8]},  32'h0012);
        chk("p4_beq_20",  {16'b0, rd_q[base+9]},  32'h0020);
        chk("p4_jal_2A",  {16'b0, rd_q[base+10]}, 32'h002A);
        chk("p4_jr_22",   {16'b0, rd_q[base+11]}, 32'h0022);
        chk("p4_r15", {16'b0, dut.u_regfile.r_regs[15]}, 32'h0022);
        chk("p4_retired", retired_cnt, exp_ret4);

        // ---------------- phase 5: reset during SW wait -----------------
        RESET = 1'b0;
        mwait = 5;
        @(negedge CLK);
        ld(16'h00, 16'h7032);   // SW r3,2(r0)
        ld(16'h02, 16'hF000);
        base  = rd_q.size();
        wbase = wr_cnt;
        RESET = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge CLK);
            n++;
            if (mif.req && mif.we) seen = 1'b1;
        end
        chk("p5_sw_seen", {31'b0, seen}, 32'd1);
        #1 RESET = 1'b0;
        #1;
        chk("p5_req_drop", {31'b0, mif.req}, 32'd0);
        repeat (3) @(negedge CLK);
        chk("p5_no_write", wr_cnt - wbase, 32'd0);
        chk("p5_pc_reset", {16'b0, pc_out}, 32'h0);
        RESET = 1'b1;
        n = 0;
        while (rd_q.size() < base + 2 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("p5_refetch_len", rd_q.size() - base, 32'd2);
        chk("p5_refetch_pc", {16'b0, rd_q[base+1]}, 32'h0000);
        chk("p5_no_write2", wr_cnt - wbase, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Next-generation 16-bit-ISA processor core: multi-cycle datapath with an explicit FSM, replacing the single-cycle organisation.
- One shared instruction/data memory port with a req/ack handshake, so external memory may insert wait states.
- Data width is parametrised; instruction encoding stays 16-bit, with fields op[15:12] rs[11:8] rt[7:4] rd[3:0].
- Sits between the board-level memory/IO fabric and the debug display logic.

Parameters:
- DATA_W, 16: register/ALU/memory data width, >=16; immediates sign-extend to DATA_W.
- ADDR_W, 16: byte address width of the memory port and PC.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle; instruction fetch uses [15:0].
- mem_ack  in  1  one-cycle completion strobe.
- halted  out  1  core is in HALT.
- pc_out  out  ADDR_W  current PC.
- instr_out  out  16  current instruction register.
- cycle_cnt  out  32  performance counter (see Optional Feature).
- retired_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
Reset (RESET low, async):
- PC = RESET_PC; IR = 0; all registers = 0.
- State = FETCH; mem_req = 0; halted = 0; counters = 0.
- Reset mid-transaction drops mem_req immediately; the abandoned ack is ignored.

FSM states and transitions:
- FETCH: assert mem_req (rd, addr = PC). On ack: IR <= rdata[15:0], PC <= PC+2, go DECODE.
- DECODE: A <= R[rs], B <= R[rt]. R0 always reads 0; writes to R0 are discarded. Go EXEC.
- EXEC: compute ALUout.
  - ADD/SUB/AND/OR/SLT go WB.
  - ADDI/LW/SW go WB/MEM/MEM.
  - BEQ/JAL/JR go FETCH (JAL also writes R15 here).
  - HALT goes HALT.
- MEM: assert mem_req, addr = ALUout. SW: we = 1, wdata = B, go FETCH on ack. LW: MDR <= rdata, go WB on ack.
- WB: write destination register, go FETCH.
- HALT: terminal; left only by reset.

Opcode map (4-bit):
- 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR.
- 4 SLT rd = (signed rs < signed rt).
- 5 ADDI rt = rs + sext(imm4); imm4 = IR[3:0].
- 6 LW rt = M[rs + sext(imm4)]; 7 SW M[rs + sext(imm4)] = rt.
- 8 BEQ: if rs == rt, PC <= PC + (sext(imm4) << 1).
- 9 JAL: R15 <= PC; PC <= PC + (sext(IR[7:0]) << 1).
- A JR: PC <= rs[ADDR_W-1:0].
- F HALT.
- B-E undefined: treated as NOP, go FETCH.

Timing and arithmetic:
- Arithmetic wraps modulo 2^DATA_W; PC wraps modulo 2^ADDR_W.
- "PC" in branch/jump targets is the already-incremented PC.
- Latency with zero wait states (ack in the first req cycle):
  - ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/JAL/JR: 3 cycles.
- Each wait cycle adds 1.
- mem_addr, mem_we and mem_wdata are stable while mem_req is high. mem_req deasserts in the cycle after ack.
- Unaligned addresses are passed through unchanged.

Optional Feature:
- Macro: MULTICYCLE_CPU_PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every cycle outside HALT.
  - retired_cnt increments on every transition into FETCH from DECODE/EXEC/MEM/WB, plus once on entering HALT.
  - Both counters wrap at 2^32.
- When not defined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package multicycle_cpu_pkg holds the opcode localparams and the state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT).
- One sub-module, mc_regfile: 16 x DATA_W, 2 async read ports, 1 sync write port, R0 hardwired to 0. Async-reset-low clear.
- The ALU stays inline.

Test Plan:
- Reset then ADDI r1,r0,5 ; ADDI r2,r0,-3 ; ADD r3,r1,r2 with zero-wait memory -> r3 = 2; ADD retires 4 cycles after ADDI r2 retires.
- SW r3,2(r0) then LW r4,2(r0), memory acks after 3 wait cycles -> write at addr 0x0002 with wdata = 2, req held 4 cycles; r4 = 2.
- BEQ r1,r1,-2 at PC 0x0010 -> next fetch at 0x000E. BEQ r1,r2,... not taken -> next fetch 0x0012.
- JAL imm8 = 4 at PC 0x0020 -> R15 = 0x0022, next fetch 0x002A. JR r15 -> next fetch 0x0022.
- RESET low during the MEM wait of a SW -> mem_req low immediately; no write; fetch restarts at RESET_PC after release.
- HALT with PERF_CNT_EN defined -> halted = 1 and mem_req stays 0 for 20 cycles; cycle_cnt frozen; retired_cnt equals the instruction count. DATA_W = 32 run: ADDI r1,r0,-1 -> r1 = 0xFFFF_FFFF.
